dcache_direct_wb: RTL and testbench

// - Responder on the pipeline's D_cache port. Answers DCACHE_ren/DCACHE_wen word requests

---
 rtl/dcache_pkg.sv | 17 +
 rtl/dcache_if.sv | 27 ++
 rtl/dcache_line_array.sv | 57 +++++
 rtl/dcache_direct_wb.sv | 102 ++++++++++
 tb/tb_dcache_direct_wb.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and widths for the direct-mapped write-back data cache
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WB, FILL} dcache_state_t;

  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W         = LINE_W / WORDS_PER_LINE;
  localparam int OFF_W          = 2;
  localparam int DEF_IDX_W      = 3;
  localparam int DEF_ADDR_W     = 30;

  function automatic int tag_width(int addr_w, int idx_w);
    return addr_w - OFF_W - idx_w;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - processor-side and memory-side signals of the data cache
interface dcache_if import dcache_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W);

  logic                proc_read;
  logic                proc_write;
  logic [ADDR_W-1:0]   proc_addr;
  logic [WORD_W-1:0]   proc_wdata;
  logic                proc_stall;
  logic [WORD_W-1:0]   proc_rdata;
  logic                mem_read;
  logic                mem_write;
  logic [ADDR_W-3:0]   mem_addr;
  logic [LINE_W-1:0]   mem_wdata;
  logic [LINE_W-1:0]   mem_rdata;
  logic                mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_line_array.sv
// rtl/dcache_line_array.sv - tag/valid/dirty/data storage with word-write and line-fill ports
module dcache_line_array import dcache_pkg::*; #(
  parameter int IDX_W = DEF_IDX_W,
  parameter int TAG_W = tag_width(DEF_ADDR_W, DEF_IDX_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              word_en,
  input  logic [IDX_W-1:0]  word_idx,
  input  logic [OFF_W-1:0]  word_off,
  input  logic [WORD_W-1:0] word_data,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_data
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tags [LINES];
  logic [LINE_W-1:0] data [LINES];

  // Only the bookkeeping bits are reset; line contents are meaningless until valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[fill_idx] <= 1'b1;
      dirty[fill_idx] <= 1'b0;
    end else if (word_en) begin
      dirty[word_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= fill_data;
    end else if (word_en) begin
      data[word_idx][word_off*WORD_W +: WORD_W] <= word_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_line  = data[rd_idx];

endmodule

// File: rtl/dcache_direct_wb.sv
// rtl/dcache_direct_wb.sv - direct-mapped write-back write-allocate data cache with 4-word lines
module dcache_direct_wb import dcache_pkg::*; #(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic    clk,
  input logic    rst_n,
  dcache_if.slave bus
);

  localparam int TAG_W = tag_width(ADDR_W, IDX_W);

  dcache_state_t     state;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  addr_tag;
  logic [IDX_W-1:0]  addr_idx;
  logic [OFF_W-1:0]  addr_off;
  logic [IDX_W-1:0]  idx;
  logic              req, hit, miss;
  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;

  assign addr_tag = bus.proc_addr[ADDR_W-1 -: TAG_W];
  assign addr_idx = bus.proc_addr[OFF_W +: IDX_W];
  assign addr_off = bus.proc_addr[OFF_W-1:0];

  // Outside IDLE the array must keep looking at the latched request's line.
  assign idx  = (state == IDLE) ? addr_idx : req_idx;
  assign req  = bus.proc_read | bus.proc_write;
  assign hit  = (state == IDLE) & req & rd_valid & (rd_tag == addr_tag);
  assign miss = (state == IDLE) & req & ~hit;

  assign bus.proc_stall = (state != IDLE) | miss;
  assign bus.proc_rdata = hit ? rd_line[addr_off*WORD_W +: WORD_W] : '0;

  dcache_line_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_lines (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .word_en   (hit & bus.proc_write),
    .word_idx  (addr_idx),
    .word_off  (addr_off),
    .word_data (bus.proc_wdata),
    .fill_en   ((state == FILL) & bus.mem_ready),
    .fill_idx  (req_idx),
    .fill_tag  (req_tag),
    .fill_data (bus.mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_tag       <= '0;
      req_idx       <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            req_tag <= addr_tag;
            req_idx <= addr_idx;
            if (rd_valid & rd_dirty) begin
              bus.mem_write <= 1'b1;
              bus.mem_addr  <= {rd_tag, addr_idx};
              bus.mem_wdata <= rd_line;
              state         <= WB;
            end else begin
              bus.mem_read <= 1'b1;
              bus.mem_addr <= {addr_tag, addr_idx};
              state        <= FILL;
            end
          end
        end
        WB: begin
          if (bus.mem_ready) begin
            bus.mem_write <= 1'b0;
            bus.mem_read  <= 1'b1;
            bus.mem_addr  <= {req_tag, req_idx};
            state         <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_ready) begin
            bus.mem_read <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// tb/tb_dcache_direct_wb.sv - self-checking bench for dcache_direct_wb
module tb_dcache_direct_wb;
  import dcache_pkg::*;

  localparam int IDX_W  = 3;
  localparam int ADDR_W = 30;

  typedef struct {
    bit          rd;
    bit          wr;
    int          addr;
    logic [31:0] wd;
    bit          chk_rd;
    logic [31:0] exp_rd;
    int          exp_nr;
    int          exp_nw;
  } vec_t;

  typedef struct {
    bit           wr;
    int           addr;
    logic [127:0] data;
  } log_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lat = 4;
  int   nreads = 0;
  int   nwrites = 0;

  logic [127:0] mem_model [int];
  logic [31:0]  golden [int];
  log_t         mem_log [$];
  vec_t         vecs [$];

  dcache_if #(.ADDR_W(ADDR_W)) bus();

  dcache_direct_wb #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int a);
    return (32'(a) * 32'h0100_0193) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] gword(int a);
    if (golden.exists(a)) return golden[a];
    return init_word(a);
  endfunction

  function automatic logic [127:0] mem_line(int la);
    logic [127:0] l;
    if (mem_model.exists(la)) return mem_model[la];
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = init_word(la*4 + k);
    return l;
  endfunction

  function automatic vec_t mk(bit rd, bit wr, int addr, logic [31:0] wd, bit chk_rd,
                              logic [31:0] exp_rd, int exp_nr, int exp_nw);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.chk_rd = chk_rd;
    v.exp_rd = exp_rd; v.exp_nr = exp_nr; v.exp_nw = exp_nw;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: one-cycle mem_ready pulse after lat+1 cycles of a held request.
  initial begin
    int   cnt;
    log_t e;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
      end else if (bus.mem_read || bus.mem_write) begin
        check("mem_rw_exclusive", bus.mem_read & bus.mem_write, 1'b0);
        if (cnt >= lat) begin
          e.wr   = bus.mem_write;
          e.addr = int'(bus.mem_addr);
          e.data = bus.mem_wdata;
          if (bus.mem_write) begin
            mem_model[e.addr] = bus.mem_wdata;
            nwrites++;
          end else begin
            bus.mem_rdata = mem_line(e.addr);
            nreads++;
          end
          mem_log.push_back(e);
          bus.mem_ready = 1'b1;
          cnt = 0;
          @(posedge clk);
          #1;
          bus.mem_ready = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic access(input bit rd, input bit wr, input int addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output int cyc, output int nr, output int nw);
    int r0, w0;
    @(posedge clk);
    #1;
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = addr[ADDR_W-1:0];
    bus.proc_wdata = wd;
    r0 = nreads;
    w0 = nwrites;
    cyc = 0;
    rdata = '0;
    forever begin
      @(negedge clk);
      if (!bus.proc_stall) begin
        rdata = bus.proc_rdata;
        break;
      end
      cyc++;
      if (cyc > 400) begin
        checks++;
        errors++;
        $display("FAIL access_timeout addr=%0h: still stalled after %0d cycles, required completion", addr, cyc);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    nr = nreads - r0;
    nw = nwrites - w0;
    if (wr) golden[addr] = wd;
  endtask

  function automatic int exp_cycles(int nr, int nw);
    if (nr + nw == 0) return 0;
    return 1 + (nr + nw) * (lat + 1);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rdata;
    int          cyc, nr, nw;
    bit          m_valid [8];
    bit          m_dirty [8];
    int          m_tag   [8];

    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;

    mem_model[4] = 128'h0000000D_0000000C_0000000B_0000000A;
    golden[16] = 32'hA; golden[17] = 32'hB; golden[18] = 32'hC; golden[19] = 32'hD;

    #3 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(negedge clk);
    check("reset_stall",  bus.proc_stall, 1'b0);
    check("reset_mem_read",  bus.mem_read, 1'b0);
    check("reset_mem_write", bus.mem_write, 1'b0);
    check("reset_mem_addr",  bus.mem_addr, '0);
    check("reset_mem_wdata", bus.mem_wdata, '0);
    check("reset_rdata",  bus.proc_rdata, '0);

    vecs.push_back(mk(1, 0, 'h10, 0,            1, 32'hA,             1, 0));
    vecs.push_back(mk(0, 1, 'h11, 32'h12345678, 0, 0,                 0, 0));
    vecs.push_back(mk(1, 0, 'h11, 0,            1, 32'h12345678,      0, 0));
    vecs.push_back(mk(1, 0, 'h10, 0,            1, 32'hA,             0, 0));
    vecs.push_back(mk(1, 0, 'h30, 0,            1, init_word('h30),   1, 1));
    vecs.push_back(mk(1, 0, 'h50, 0,            1, init_word('h50),   1, 0));
    vecs.push_back(mk(1, 0, 'h70, 0,            1, init_word('h70),   1, 0));
    vecs.push_back(mk(1, 0, 'h1C, 0,            1, init_word('h1C),   1, 0));
    vecs.push_back(mk(1, 0, 'h00, 0,            1, init_word('h00),   1, 0));
    vecs.push_back(mk(1, 0, 'h1C, 0,            1, init_word('h1C),   0, 0));
    vecs.push_back(mk(1, 1, 'h1D, 32'hCAFEF00D, 0, 0,                 0, 0));
    vecs.push_back(mk(1, 0, 'h1D, 0,            1, 32'hCAFEF00D,      0, 0));
    vecs.push_back(mk(1, 0, 'h3C, 0,            1, init_word('h3C),   1, 1));
    vecs.push_back(mk(1, 0, 'h1D, 0,            1, 32'hCAFEF00D,      1, 0));

    lat = 4;
    foreach (vecs[i]) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, rdata, cyc, nr, nw);
      check($sformatf("vec%0d_reads", i),  nr, vecs[i].exp_nr);
      check($sformatf("vec%0d_writes", i), nw, vecs[i].exp_nw);
      check($sformatf("vec%0d_stall_cycles", i), cyc, exp_cycles(vecs[i].exp_nr, vecs[i].exp_nw));
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
    end

    check("log_size", mem_log.size(), 10);
    if (mem_log.size() >= 10) begin
      check("cold_fill_op",   mem_log[0].wr, 1'b0);
      check("cold_fill_addr", mem_log[0].addr, 4);
      check("dirty_wb_op",    mem_log[1].wr, 1'b1);
      check("dirty_wb_addr",  mem_log[1].addr, 4);
      check("dirty_wb_word1", mem_log[1].data[63:32], 32'h12345678);
      check("dirty_fill_op",  mem_log[2].wr, 1'b0);
      check("dirty_fill_addr", mem_log[2].addr, 'hC);
      check("rdwr_wb_op",     mem_log[7].wr, 1'b1);
      check("rdwr_wb_addr",   mem_log[7].addr, 7);
      check("rdwr_wb_word1",  mem_log[7].data[63:32], 32'hCAFEF00D);
    end

    // Reset in the middle of a line fill.
    lat = 1000;
    @(posedge clk);
    #1;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h44;
    repeat (3) @(negedge clk);
    check("fill_mem_read",  bus.mem_read, 1'b1);
    check("fill_mem_addr",  bus.mem_addr, 28'h11);
    check("fill_stall",     bus.proc_stall, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_read", bus.mem_read, 1'b0);
    check("abort_mem_addr", bus.mem_addr, '0);
    bus.proc_read = 1'b0;
    #1;
    check("abort_stall_idle", bus.proc_stall, 1'b0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    lat = 2;
    access(1, 0, 'h00, 0, rdata, cyc, nr, nw);
    check("post_reset_refill", nr, 1);
    check("post_reset_rdata", rdata, init_word('h00));

    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 0;
    end
    m_valid[0] = 1'b1;

    // Randomized traffic against a tag/valid/dirty occupancy model and a flat word memory.
    for (int n = 0; n < 200; n++) begin
      int          addr, kind, idx, tag, enr, enw;
      bit          h;
      logic [31:0] wd, exp_rd;
      lat  = $urandom_range(0, 3);
      addr = $urandom_range(0, 127);
      kind = $urandom_range(0, 2);
      wd   = $urandom;
      idx  = (addr / 4) % 8;
      tag  = addr / 32;
      h    = m_valid[idx] && (m_tag[idx] == tag);
      enr  = h ? 0 : 1;
      enw  = (!h && m_valid[idx] && m_dirty[idx]) ? 1 : 0;
      exp_rd = gword(addr);
      access(kind != 1, kind != 0, addr, wd, rdata, cyc, nr, nw);
      check($sformatf("rnd%0d_reads", n), nr, enr);
      check($sformatf("rnd%0d_writes", n), nw, enw);
      check($sformatf("rnd%0d_stall_cycles", n), cyc, exp_cycles(enr, enw));
      if (kind == 0) check($sformatf("rnd%0d_rdata_a%0h", n, addr), rdata, exp_rd);
      if (!h) m_dirty[idx] = 1'b0;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      if (kind != 0) m_dirty[idx] = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
